// File: rtl/i2c_enc_arbiter.sv
// Round-robin arbiter sharing one I2C encoder-read master between NUM_REQ angle controllers.
// Optional transaction timeout/abort is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_enc_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*7-1:0] req_dev,
    input  logic [NUM_REQ*8-1:0] req_reg,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [15:0]          rdata,
    output logic                 i2c_start,
    output logic [6:0]           i2c_dev,
    output logic [7:0]           i2c_reg,
    input  logic                 i2c_done,
    input  logic                 i2c_nack,
    input  logic [15:0]          i2c_rdata,
    output logic                 i2c_abort
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     gidx_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 err_q;
    logic [15:0]          rdata_q;
    logic                 start_q;
    logic [6:0]           dev_q;
    logic [7:0]           reg_q;

    logic [PTR_W-1:0]     pick_d;
    logic                 pick_vld_d;
    logic [6:0]           pick_dev_d;
    logic [7:0]           pick_reg_d;
    logic [PTR_W-1:0]     rr_ptr_d;

`ifdef I2C_ARB_TIMEOUT_EN
    logic                 abort_q;
    logic [TO_W-1:0]      to_cnt_q;
`endif

    // First requester at or above rr_ptr wins; scanning downward lets the lowest offset overwrite.
    always_comb begin
        int idx;
        idx        = 0;
        pick_d     = '0;
        pick_vld_d = 1'b0;
        pick_dev_d = '0;
        pick_reg_d = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                pick_d     = PTR_W'(idx);
                pick_vld_d = 1'b1;
                pick_dev_d = req_dev[idx*7 +: 7];
                pick_reg_d = req_reg[idx*8 +: 8];
            end
        end
    end

    assign rr_ptr_d = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            start_q  <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            abort_q  <= 1'b0;
            to_cnt_q <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            abort_q <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_vld_d) begin
                        gidx_q  <= pick_d;
                        gnt_q   <= NUM_REQ'(1) << pick_d;
                        dev_q   <= pick_dev_d;
                        reg_q   <= pick_reg_d;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    start_q  <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q  <= ST_WAIT;
                end
                // done_q is raised here so the pulse lands one cycle after i2c_done.
                ST_WAIT: begin
                    if (i2c_done) begin
                        rdata_q <= i2c_rdata;
                        err_q   <= i2c_nack;
                        done_q  <= gnt_q;
                        state_q <= ST_RELEASE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        abort_q <= 1'b1;
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        state_q <= ST_RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign i2c_start = start_q;
    assign i2c_dev   = dev_q;
    assign i2c_reg   = reg_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign i2c_abort = abort_q;
`else
    assign i2c_abort = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_enc_arbiter.sv
// Randomized self-checking bench for i2c_enc_arbiter against a round-robin transaction model.
module tb_i2c_enc_arbiter;

    localparam int NR  = 4;
    localparam int TOC = 100;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NR-1:0] req;
    logic [NR*7-1:0] req_dev;
    logic [NR*8-1:0] req_reg;
    logic [NR-1:0] gnt;
    logic [NR-1:0] done;
    logic          err;
    logic [15:0]   rdata;
    logic          i2c_start;
    logic [6:0]    i2c_dev;
    logic [7:0]    i2c_reg;
    logic          i2c_done;
    logic          i2c_nack;
    logic [15:0]   i2c_rdata;
    logic          i2c_abort;

    int n_chk  = 0;
    int n_fail = 0;
    int mptr   = 0;
    logic [15:0] mrdata = '0;

    always #5 clock = ~clock;

    i2c_enc_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TOC), .TO_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_dev(req_dev), .req_reg(req_reg),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .i2c_start(i2c_start),
        .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .i2c_rdata(i2c_rdata), .i2c_abort(i2c_abort)
    );

    // Reference arbitration: first set request bit at or after the pointer, wrapping.
    function automatic int pick(input int ptr, input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // One full transaction; caller is at a negedge with the DUT idle.
    task automatic run_txn(input logic [NR-1:0] r, input logic nk, input logic [15:0] dat, input int lat);
        int e;
        logic [6:0] edev;
        logic [7:0] ereg;
        logic [NR-1:0] eg;
        e = pick(mptr, r);
        n_chk++;
        if (e < 0) begin n_fail++; $display("FAIL txn_req: got req %b, required nonzero", r); return; end
        edev = req_dev[e*7 +: 7];
        ereg = req_reg[e*8 +: 8];
        eg   = NR'(1) << e;
        req  = r;
        @(negedge clock);
        n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL gnt: got %b required %b", gnt, eg); end
        n_chk++; if (i2c_dev !== edev || i2c_reg !== ereg) begin n_fail++; $display("FAIL addr: got %h/%h required %h/%h", i2c_dev, i2c_reg, edev, ereg); end
        n_chk++; if (i2c_start !== 1'b0) begin n_fail++; $display("FAIL start_early: got %b required 0", i2c_start); end
        req_dev = 28'($urandom);
        req_reg = $urandom;
        @(negedge clock);
        n_chk++; if (i2c_start !== 1'b1) begin n_fail++; $display("FAIL start: got %b required 1", i2c_start); end
        n_chk++; if (i2c_dev !== edev || i2c_reg !== ereg || gnt !== eg) begin n_fail++; $display("FAIL hold: got %h/%h/%b required %h/%h/%b", i2c_dev, i2c_reg, gnt, edev, ereg, eg); end
        repeat (lat) begin
            @(negedge clock);
            n_chk++; if (done !== '0 || i2c_start !== 1'b0) begin n_fail++; $display("FAIL wait: got done %b start %b required 0/0", done, i2c_start); end
        end
        i2c_done  = 1'b1;
        i2c_nack  = nk;
        i2c_rdata = dat;
        @(negedge clock);
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        i2c_rdata = 16'($urandom);
        n_chk++; if (done !== eg) begin n_fail++; $display("FAIL done: got %b required %b", done, eg); end
        n_chk++; if (err !== nk) begin n_fail++; $display("FAIL err: got %b required %b", err, nk); end
        n_chk++; if (rdata !== dat) begin n_fail++; $display("FAIL rdata: got %h required %h", rdata, dat); end
        mrdata = dat;
        @(negedge clock);
        n_chk++; if (done !== '0 || gnt !== '0) begin n_fail++; $display("FAIL release: got done %b gnt %b required 0/0", done, gnt); end
        mptr = (e + 1) % NR;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req = '0; req_dev = '0; req_reg = '0;
        i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = '0;
        repeat (2) @(negedge clock);
        n_chk++; if (gnt !== '0 || done !== '0 || err !== 1'b0 || rdata !== '0) begin n_fail++; $display("FAIL reset_out: got %b %b %b %h required zeros", gnt, done, err, rdata); end
        n_chk++; if (i2c_start !== 1'b0 || i2c_dev !== '0 || i2c_reg !== '0 || i2c_abort !== 1'b0) begin n_fail++; $display("FAIL reset_i2c: got %b %h %h %b required zeros", i2c_start, i2c_dev, i2c_reg, i2c_abort); end
        reset_n = 1'b1;
        mptr = 0; mrdata = '0;
        @(negedge clock);
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (pick(mptr, 4'b1111) != i % NR) begin n_fail++; $display("FAIL rr_order: got %0d required %0d", pick(mptr, 4'b1111), i % NR); end
            run_txn(4'b1111, 1'b0, 16'($urandom), int'($urandom_range(0, 3)));
        end
        req = '0;
    endtask

    task automatic test_single;
        req_dev[13:7]  = 7'h36;
        req_reg[15:8]  = 8'h0E;
        run_txn(4'b0010, 1'b0, 16'h0A5C, 3);
        req = '0;
    endtask

    task automatic test_wrap;
        run_txn(4'b1000, 1'b0, 16'($urandom), 1);
        run_txn(4'b1001, 1'b0, 16'($urandom), 2);
        run_txn(4'b1001, 1'b0, 16'($urandom), 0);
        req = '0;
    endtask

    task automatic test_nack;
        run_txn(4'b0100, 1'b1, 16'hBEEF, 2);
        run_txn(4'b0100, 1'b0, 16'h1234, 1);
        req = '0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 3) == 0), 16'($urandom), int'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1) req = '0;
        end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_timeout;
        int e;
        int n;
        logic [NR-1:0] eg;
        e  = pick(mptr, 4'b0001);
        eg = NR'(1) << e;
        req = 4'b0001;
        @(negedge clock);
        n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL to_gnt: got %b required %b", gnt, eg); end
        @(negedge clock);
        n_chk++; if (i2c_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b required 1", i2c_start); end
`ifdef I2C_ARB_TIMEOUT_EN
        n = 0;
        for (int c = 1; c <= 250; c++) begin
            @(negedge clock);
            if (i2c_abort === 1'b1 || done !== '0) begin n = c; break; end
        end
        req = '0;
        n_chk++; if (n != TOC) begin n_fail++; $display("FAIL to_cycle: got %0d required %0d", n, TOC); end
        n_chk++; if (i2c_abort !== 1'b1 || done !== eg) begin n_fail++; $display("FAIL to_pulse: got abort %b done %b required 1/%b", i2c_abort, done, eg); end
        n_chk++; if (err !== 1'b1 || rdata !== mrdata) begin n_fail++; $display("FAIL to_data: got err %b rdata %h required 1/%h", err, rdata, mrdata); end
        @(negedge clock);
        n_chk++; if (i2c_abort !== 1'b0 || gnt !== '0) begin n_fail++; $display("FAIL to_release: got abort %b gnt %b required 0/0", i2c_abort, gnt); end
        mptr = (e + 1) % NR;
`else
        n = 0;
        repeat (300) begin
            @(negedge clock);
            if (done !== '0 || i2c_abort !== 1'b0 || gnt !== eg) n++;
        end
        n_chk++; if (n != 0) begin n_fail++; $display("FAIL no_timeout: got %0d bad cycles required 0", n); end
        i2c_done = 1'b1; i2c_nack = 1'b0; i2c_rdata = 16'h5A5A;
        @(negedge clock);
        i2c_done = 1'b0; req = '0;
        n_chk++; if (done !== eg || err !== 1'b0 || rdata !== 16'h5A5A) begin n_fail++; $display("FAIL late_done: got %b %b %h required %b 0 5a5a", done, err, rdata, eg); end
        mrdata = 16'h5A5A;
        @(negedge clock);
        mptr = (e + 1) % NR;
`endif
        @(negedge clock);
    endtask

    task automatic test_reset_wait;
        req = 4'b0001;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL async_rst: got gnt %b required 0", gnt); end
        repeat (3) @(negedge clock);
        n_chk++; if (gnt !== '0 || done !== '0 || err !== 1'b0 || rdata !== '0 || i2c_start !== 1'b0 || i2c_dev !== '0 || i2c_reg !== '0 || i2c_abort !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait: got %b %b %b %h %b %h %h %b required zeros", gnt, done, err, rdata, i2c_start, i2c_dev, i2c_reg, i2c_abort);
        end
        req = '0;
        reset_n = 1'b1;
        mptr = 0; mrdata = '0;
        @(negedge clock);
        i2c_done = 1'b1; i2c_nack = 1'b1; i2c_rdata = 16'hFFFF;
        @(negedge clock);
        i2c_done = 1'b0; i2c_nack = 1'b0;
        repeat (3) begin
            @(negedge clock);
            n_chk++; if (done !== '0 || err !== 1'b0 || rdata !== '0 || gnt !== '0) begin n_fail++; $display("FAIL spurious: got %b %b %h %b required zeros", done, err, rdata, gnt); end
        end
        run_txn(4'b1111, 1'b0, 16'($urandom), 1);
        req = '0;
        run_txn(4'b0100, 1'b0, 16'($urandom), 2);
        req = '0;
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_wrap;
        test_nack;
        test_random;
        test_timeout;
        test_reset_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
